// File: rtl/load_store_unit.sv
// load_store_unit: RV32 load/store decode, alignment check, load extension, 2-entry result buffer.
// Rev 1.0
`default_nettype none

module load_store_unit #(
  parameter  int REG_ADDR_W     = 5,
  localparam int ADDR_W         = 32,
  localparam int WORD_W         = 32,
  localparam int MEM_COUNT_W    = 2,
  localparam int MEM_CODE_W     = 2,
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0,
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1,
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2,
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3,
  localparam logic [MEM_CODE_W-1:0]  MEM_CODE_READ  = 2'd1,
  localparam logic [MEM_CODE_W-1:0]  MEM_CODE_WRITE = 2'd2
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_is_load,
  input  logic                   i_is_store,
  input  logic [2:0]             i_funct3,
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic [WORD_W-1:0]      i_wr_data,
  input  logic [REG_ADDR_W-1:0]  i_rd,
  output logic [ADDR_W-1:0]      o_req_addr,
  output logic [WORD_W-1:0]      o_req_wr_data,
  output logic [MEM_COUNT_W-1:0] o_req_count,
  output logic                   o_req_wr_en,
  input  logic [WORD_W-1:0]      i_res_rd_data,
  input  logic [MEM_CODE_W-1:0]  i_res_code,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [REG_ADDR_W-1:0]  o_rd,
  output logic [WORD_W-1:0]      o_rd_data,
  output logic                   o_rd_wr_en,
  output logic [1:0]             o_exc
);

  typedef enum logic [1:0] {
    OP_ALU   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } op_t;

  // ---------------- input decode ----------------
  logic                   acc;
  logic                   pop;
  op_t                    op_class;
  logic [MEM_COUNT_W-1:0] width;
  logic                   illegal;
  logic                   misaligned;
  logic [1:0]             exc_in;
  logic                   issue;

  always_comb begin
    op_class = OP_ALU;
    if (i_is_load)       op_class = OP_LOAD;
    else if (i_is_store) op_class = OP_STORE;

    case (i_funct3[1:0])
      2'b00:   width = MEM_COUNT_BYTE;
      2'b01:   width = MEM_COUNT_HALF;
      2'b10:   width = MEM_COUNT_WORD;
      default: width = MEM_COUNT_NONE;
    endcase

    // Stores have no unsigned variants, so funct3[2] is illegal for them.
    illegal = (op_class != OP_ALU) &&
              ((i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11) ||
               ((op_class == OP_STORE) && i_funct3[2]));
    misaligned = (op_class != OP_ALU) &&
                 (((width == MEM_COUNT_HALF) && i_addr[0]) ||
                  ((width == MEM_COUNT_WORD) && (i_addr[1:0] != 2'b00)));

    exc_in = 2'd0;
    if (illegal)         exc_in = 2'd2;
    else if (misaligned) exc_in = 2'd1;

    issue = acc && (op_class != OP_ALU) && (exc_in == 2'd0);
  end

  assign acc           = i_valid && o_ready;
  assign o_req_count   = issue ? width : MEM_COUNT_NONE;
  assign o_req_wr_en   = issue && (op_class == OP_STORE);
  assign o_req_addr    = acc ? i_addr : '0;
  assign o_req_wr_data = acc ? i_wr_data : '0;

  // ---------------- S1: waits one cycle for the memory response ----------------
  logic                  s1_valid;
  logic [REG_ADDR_W-1:0] s1_rd;
  logic [2:0]            s1_funct3;
  op_t                   s1_op;
  logic [1:0]            s1_exc;
  logic                  s1_issued;
  logic [ADDR_W-1:0]     s1_addr;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      s1_valid  <= 1'b0;
      s1_rd     <= '0;
      s1_funct3 <= '0;
      s1_op     <= OP_ALU;
      s1_exc    <= '0;
      s1_issued <= 1'b0;
      s1_addr   <= '0;
    end else begin
      s1_valid <= acc;
      if (acc) begin
        s1_rd     <= i_rd;
        s1_funct3 <= i_funct3;
        s1_op     <= op_class;
        s1_exc    <= exc_in;
        s1_issued <= issue;
        s1_addr   <= i_addr;
      end
    end
  end

  logic [MEM_CODE_W-1:0] expected_code;
  logic [1:0]            res_exc;
  logic [WORD_W-1:0]     load_ext;
  logic [WORD_W-1:0]     res_data;
  logic                  res_we;

  always_comb begin
    expected_code = (s1_op == OP_STORE) ? MEM_CODE_WRITE : MEM_CODE_READ;
    res_exc = s1_exc;
    if (s1_issued && (i_res_code != expected_code)) res_exc = 2'd3;

    case (s1_funct3)
      3'b000:  load_ext = {{24{i_res_rd_data[7]}}, i_res_rd_data[7:0]};
      3'b100:  load_ext = {24'd0, i_res_rd_data[7:0]};
      3'b001:  load_ext = {{16{i_res_rd_data[15]}}, i_res_rd_data[15:0]};
      3'b101:  load_ext = {16'd0, i_res_rd_data[15:0]};
      default: load_ext = i_res_rd_data;
    endcase

    res_data = '0;
    res_we   = 1'b0;
    if (res_exc == 2'd0) begin
      case (s1_op)
        OP_LOAD: begin
          res_data = load_ext;
          res_we   = 1'b1;
        end
        OP_ALU: begin
          res_data = WORD_W'(s1_addr);
          res_we   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- 2-entry output buffer ----------------
  logic [REG_ADDR_W-1:0] buf_rd   [2];
  logic [WORD_W-1:0]     buf_data [2];
  logic                  buf_we   [2];
  logic [1:0]            buf_exc  [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            buf_count;
  logic [2:0]            occupancy;

  assign pop = o_valid && i_ready;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      buf_count <= 2'd0;
    end else begin
      if (s1_valid) wr_ptr <= ~wr_ptr;
      if (pop)      rd_ptr <= ~rd_ptr;
      buf_count <= buf_count + 2'(s1_valid) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (s1_valid) begin
      buf_rd[wr_ptr]   <= s1_rd;
      buf_data[wr_ptr] <= res_data;
      buf_we[wr_ptr]   <= res_we;
      buf_exc[wr_ptr]  <= res_exc;
    end
  end

  // Accept only if next cycle's S1 push still fits in the buffer.
  assign occupancy = 3'(buf_count) + 3'(s1_valid) - 3'(pop);
  assign o_ready   = aresetn && (occupancy <= 3'd1);

  assign o_valid    = (buf_count != 2'd0);
  assign o_rd       = o_valid ? buf_rd[rd_ptr]   : '0;
  assign o_rd_data  = o_valid ? buf_data[rd_ptr] : '0;
  assign o_rd_wr_en = o_valid && buf_we[rd_ptr];
  assign o_exc      = o_valid ? buf_exc[rd_ptr]  : 2'd0;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed test of load_store_unit with a small behavioural memory.
// Rev 1.0
`default_nettype none

module tb_load_store_unit;

  localparam logic [1:0] CNT_NONE = 2'd0;
  localparam logic [1:0] CNT_BYTE = 2'd1;
  localparam logic [1:0] CNT_HALF = 2'd2;
  localparam logic [1:0] CNT_WORD = 2'd3;
  localparam logic [1:0] CODE_IDLE  = 2'd0;
  localparam logic [1:0] CODE_READ  = 2'd1;
  localparam logic [1:0] CODE_WRITE = 2'd2;
  localparam logic [1:0] CODE_FAULT = 2'd3;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        i_valid;
  logic        o_ready;
  logic        i_is_load;
  logic        i_is_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wr_data;
  logic [4:0]  i_rd;
  logic [31:0] o_req_addr;
  logic [31:0] o_req_wr_data;
  logic [1:0]  o_req_count;
  logic        o_req_wr_en;
  logic [31:0] i_res_rd_data;
  logic [1:0]  i_res_code;
  logic        o_valid;
  logic        i_ready;
  logic [4:0]  o_rd;
  logic [31:0] o_rd_data;
  logic        o_rd_wr_en;
  logic [1:0]  o_exc;

  int passed = 0;
  int total  = 0;
  logic fault_inj = 1'b0;

  always #5 clk = ~clk;

  load_store_unit #(.REG_ADDR_W(5)) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_is_load     (i_is_load),
    .i_is_store    (i_is_store),
    .i_funct3      (i_funct3),
    .i_addr        (i_addr),
    .i_wr_data     (i_wr_data),
    .i_rd          (i_rd),
    .o_req_addr    (o_req_addr),
    .o_req_wr_data (o_req_wr_data),
    .o_req_count   (o_req_count),
    .o_req_wr_en   (o_req_wr_en),
    .i_res_rd_data (i_res_rd_data),
    .i_res_code    (i_res_code),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_rd          (o_rd),
    .o_rd_data     (o_rd_data),
    .o_rd_wr_en    (o_rd_wr_en),
    .o_exc         (o_exc)
  );

  // Behavioural memory_interface: samples the request at the edge, answers next cycle.
  logic [7:0] mem [256];
  wire  [7:0] ma = o_req_addr[7:0];

  always @(posedge clk) begin
    if (!aresetn) begin
      i_res_code    <= CODE_IDLE;
      i_res_rd_data <= '0;
    end else begin
      i_res_code    <= CODE_IDLE;
      i_res_rd_data <= '0;
      if (o_req_count != CNT_NONE) begin
        if (o_req_wr_en) begin
          mem[ma] <= o_req_wr_data[7:0];
          if (o_req_count != CNT_BYTE) mem[ma + 8'd1] <= o_req_wr_data[15:8];
          if (o_req_count == CNT_WORD) begin
            mem[ma + 8'd2] <= o_req_wr_data[23:16];
            mem[ma + 8'd3] <= o_req_wr_data[31:24];
          end
          i_res_code <= fault_inj ? CODE_FAULT : CODE_WRITE;
        end else begin
          case (o_req_count)
            CNT_BYTE: i_res_rd_data <= {24'd0, mem[ma]};
            CNT_HALF: i_res_rd_data <= {16'd0, mem[ma + 8'd1], mem[ma]};
            default:  i_res_rd_data <= {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
          endcase
          i_res_code <= fault_inj ? CODE_FAULT : CODE_READ;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One isolated operation: request checked at accept, result checked one cycle after E1.
  task automatic op(input logic ld, input logic st, input logic [2:0] f3,
                    input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                    input logic [1:0] exp_cnt, input logic exp_we, input logic [31:0] exp_data,
                    input logic exp_rdwe, input logic [1:0] exp_exc, input string tag);
    @(negedge clk);
    i_valid = 1'b1; i_is_load = ld; i_is_store = st; i_funct3 = f3;
    i_addr = addr; i_wr_data = wdata; i_rd = rd;
    #1;
    check({tag, ".ready"}, o_ready, 1);
    check({tag, ".req_count"}, o_req_count, exp_cnt);
    check({tag, ".req_wr_en"}, o_req_wr_en, exp_we);
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0;
    check({tag, ".early_valid"}, o_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check({tag, ".valid"}, o_valid, 1);
    check({tag, ".rd"}, o_rd, rd);
    check({tag, ".rd_wr_en"}, o_rd_wr_en, exp_rdwe);
    check({tag, ".exc"}, o_exc, exp_exc);
    if (exp_exc == 2'd0) check({tag, ".rd_data"}, o_rd_data, exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] bp_data [8];
  logic        acc_now;
  logic        saw_drop;
  logic        holding;
  logic [31:0] hold_data;
  int          in_idx;
  int          out_idx;

  initial begin
    aresetn = 1'b0; i_valid = 1'b1; i_is_load = 1'b1; i_is_store = 1'b0;
    i_funct3 = 3'b010; i_addr = 32'h40; i_wr_data = '0; i_rd = 5'd1; i_ready = 1'b1;

    // Reset, with a load pending on the input
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst.valid", o_valid, 0);
      check("rst.req_count", o_req_count, CNT_NONE);
      check("rst.ready", o_ready, 0);
    end
    @(negedge clk);
    i_valid = 1'b0; i_is_load = 1'b0;
    aresetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst.ready_after", o_ready, 1);
    check("rst.valid_after", o_valid, 0);

    // Store then load
    op(0, 1, 3'b010, 32'h40, 32'hDEADBEEF, 5'd5, CNT_WORD, 1, 32'h0, 0, 2'd0, "sw40");
    op(1, 0, 3'b010, 32'h40, 32'h0, 5'd6, CNT_WORD, 0, 32'hDEADBEEF, 1, 2'd0, "lw40");

    // Load extension
    op(0, 1, 3'b000, 32'h13, 32'h00000080, 5'd7, CNT_BYTE, 1, 32'h0, 0, 2'd0, "sb13");
    op(0, 1, 3'b001, 32'h20, 32'h00008001, 5'd7, CNT_HALF, 1, 32'h0, 0, 2'd0, "sh20");
    op(1, 0, 3'b000, 32'h13, 32'h0, 5'd8,  CNT_BYTE, 0, 32'hFFFFFF80, 1, 2'd0, "lb13");
    op(1, 0, 3'b100, 32'h13, 32'h0, 5'd9,  CNT_BYTE, 0, 32'h00000080, 1, 2'd0, "lbu13");
    op(1, 0, 3'b001, 32'h20, 32'h0, 5'd10, CNT_HALF, 0, 32'hFFFF8001, 1, 2'd0, "lh20");
    op(1, 0, 3'b101, 32'h20, 32'h0, 5'd11, CNT_HALF, 0, 32'h00008001, 1, 2'd0, "lhu20");

    // Alignment and illegal encodings
    op(1, 0, 3'b001, 32'h21, 32'h0, 5'd12, CNT_NONE, 0, 32'h0, 0, 2'd1, "lh21");
    op(1, 0, 3'b010, 32'h22, 32'h0, 5'd13, CNT_NONE, 0, 32'h0, 0, 2'd1, "lw22");
    op(0, 1, 3'b010, 32'h23, 32'h1234, 5'd14, CNT_NONE, 0, 32'h0, 0, 2'd1, "sw23");
    op(1, 0, 3'b011, 32'h40, 32'h0, 5'd15, CNT_NONE, 0, 32'h0, 0, 2'd2, "ld011");
    op(0, 1, 3'b100, 32'h40, 32'h0, 5'd16, CNT_NONE, 0, 32'h0, 0, 2'd2, "st100");

    // Non-memory pass-through
    op(0, 0, 3'b000, 32'h12345678, 32'h0, 5'd17, CNT_NONE, 0, 32'h12345678, 1, 2'd0, "alu");

    // Memory fault
    fault_inj = 1'b1;
    op(1, 0, 3'b010, 32'h40, 32'h0, 5'd18, CNT_WORD, 0, 32'h0, 0, 2'd3, "fault");
    fault_inj = 1'b0;

    // Reset mid-operation discards the in-flight result
    @(negedge clk);
    i_valid = 1'b1; i_is_load = 1'b0; i_is_store = 1'b0; i_addr = 32'h55; i_rd = 5'd19;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0; aresetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst.valid", o_valid, 0);
    aresetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst.valid_after", o_valid, 0);
    check("midrst.ready_after", o_ready, 1);

    // Backpressure: preload 8 words, then stream 8 loads with a 4-cycle stall
    bp_data[0] = 32'h11112222; bp_data[1] = 32'h33334444;
    bp_data[2] = 32'h55556666; bp_data[3] = 32'h77778888;
    bp_data[4] = 32'h9999AAAA; bp_data[5] = 32'hBBBBCCCC;
    bp_data[6] = 32'hDDDDEEEE; bp_data[7] = 32'hF0F0A5A5;
    for (int k = 0; k < 8; k++)
      op(0, 1, 3'b010, 32'h80 + 32'(k * 4), bp_data[k], 5'd20, CNT_WORD, 1, 32'h0, 0, 2'd0, "bp.store");

    in_idx = 0; out_idx = 0; saw_drop = 1'b0; holding = 1'b0; hold_data = '0;
    for (int cyc = 0; cyc < 60 && out_idx < 8; cyc++) begin
      @(negedge clk);
      i_ready = !(cyc >= 3 && cyc <= 6);
      if (in_idx < 8) begin
        i_valid = 1'b1; i_is_load = 1'b1; i_is_store = 1'b0; i_funct3 = 3'b010;
        i_addr = 32'h80 + 32'(in_idx * 4); i_rd = 5'(in_idx + 8);
      end else begin
        i_valid = 1'b0; i_is_load = 1'b0;
      end
      #1;
      if (!i_ready && !o_ready && o_valid) saw_drop = 1'b1;
      if (o_valid && !i_ready) begin
        if (holding) check("bp.stable", o_rd_data, hold_data);
        hold_data = o_rd_data;
        holding = 1'b1;
      end else begin
        holding = 1'b0;
      end
      if (o_valid && i_ready) begin
        check("bp.data", o_rd_data, bp_data[out_idx]);
        check("bp.rd", o_rd, 32'(out_idx + 8));
        check("bp.rd_wr_en", o_rd_wr_en, 1);
        out_idx++;
      end
      acc_now = i_valid && o_ready;
      @(posedge clk);
      if (acc_now) in_idx++;
    end
    @(negedge clk);
    i_valid = 1'b0; i_is_load = 1'b0;
    check("bp.count", out_idx, 8);
    check("bp.ready_dropped", saw_drop, 1);
    @(posedge clk);
    @(negedge clk);
    check("bp.no_extra", o_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Pipeline memory stage that sits directly upstream of `memory_interface`. It accepts execute-stage results over a valid/ready handshake and decodes RV32 load/store `funct3` into `memory_interface` requests. It checks alignment, then sign- or zero-extends returned load data. Results go to writeback through a 2-entry output buffer, so downstream stalls never drop a `memory_interface` response.

## Interface
Parameters:
- `REG_ADDR_W`, default 5, destination register index width.

Ports:
- `clk`  in  1  rising-edge clock.
- `aresetn`  in  1  reset: synchronous, active-low.
- `i_valid`  in  1  execute-stage result valid.
- `o_ready`  out  1  stage accepts an input this cycle.
- `i_is_load`  in  1  instruction is a load.
- `i_is_store`  in  1  instruction is a store.
- `i_funct3`  in  3  RV32 load/store width and sign.
- `i_addr`  in  `ADDR_W`  effective address; doubles as pass-through ALU result.
- `i_wr_data`  in  `WORD_W`  store data, right-aligned.
- `i_rd`  in  `REG_ADDR_W`  destination register.
- `o_req_addr`  out  `ADDR_W`  to `memory_interface`.
- `o_req_wr_data`  out  `WORD_W`  to `memory_interface`.
- `o_req_count`  out  `MEM_COUNT_W`  `MEM_COUNT_NONE`/`BYTE`/`HALF`/`WORD`.
- `o_req_wr_en`  out  1  to `memory_interface`.
- `i_res_rd_data`  in  `WORD_W`  from `memory_interface`, right-aligned, zero-filled.
- `i_res_code`  in  `MEM_CODE_W`  from `memory_interface`.
- `o_valid`  out  1  writeback result valid.
- `i_ready`  in  1  writeback accepts.
- `o_rd`  out  `REG_ADDR_W`  destination register.
- `o_rd_data`  out  `WORD_W`  writeback data.
- `o_rd_wr_en`  out  1  register-file write enable.
- `o_exc`  out  2  0 none, 1 misaligned, 2 illegal, 3 memory fault.

## Operation
- **Accept:** an input is accepted when `acc = i_valid & o_ready`.
- **`o_ready`:** `o_ready = (buf_count + s1_valid - (o_valid & i_ready)) <= 1`. It is combinational from `i_ready`.
- **Request decode:** requests are combinational from the inputs and are issued only when `acc`.
- **Count and write enable:** `i_funct3` 000/100 gives BYTE, 001/101 gives HALF, 010 gives WORD. `o_req_wr_en = i_is_store`.
- **Suppressed requests:** `o_req_count = MEM_COUNT_NONE` and `o_req_wr_en = 0` when any of these hold:
  - not `acc`;
  - neither load nor store;
  - misaligned (HALF with `addr[0]`, WORD with `addr[1:0] != 0`);
  - illegal (`funct3` 011/110/111, or store with `funct3[2]` set).
- **S1 register:** captures `rd`, `funct3`, the op class and the precomputed `exc` on `acc`. It resolves on the next cycle using `i_res_*`.
- **Result formatting:**
  - LB: sign-extend bit 7. LBU: zero-extend bit 7.
  - LH: sign-extend bit 15. LHU: zero-extend bit 15.
  - LW: pass the word unchanged.
  - Store: `rd_wr_en = 0`, `rd_data = 0`.
  - Non-memory op: `rd_data` = registered `i_addr`, `rd_wr_en = 1`.
- **Memory fault:** if a request was issued and `i_res_code` is not `MEM_CODE_READ` (load) or `MEM_CODE_WRITE` (store), then `exc = 3`.
- **Any exception:** forces `rd_wr_en = 0`.
- **Output buffer:** 2-entry FIFO; the head drives the `o_*` outputs. A resolved S1 entry is pushed every cycle `s1_valid` is set; push and pop in the same cycle are allowed. The `o_ready` rule guarantees the buffer never overflows.
- **Result order:** results leave in acceptance order.

## Timing
- **Reset:** synchronous reset (`aresetn == 0` at a rising edge) clears `s1_valid` and `buf_count`. All outputs read 0; `o_req_count = MEM_COUNT_NONE`. `o_ready = 0` while `aresetn` is low.
- **Reset mid-operation:** in-flight S1 and buffered results are discarded with no writeback.
- **Request timing:** the request is visible in the cycle the input is accepted (edge E0). `memory_interface` samples it at E0, and its response is valid during the cycle after E0.
- **Latency:** the result is pushed at E1. `o_valid` rises in the cycle after E1, so accept-to-`o_valid` is one cycle when the buffer is empty.
- **Throughput:** one result per cycle while `i_ready` is held high.
- **Downstream stall:** after `i_ready` goes low, at most 2 further results are held. `o_ready` drops once S1 plus the buffer reach 2 entries.
- **Output stability:** `o_*` outputs hold stable while `o_valid & !i_ready`.

## Test plan
- **Reset:** hold `aresetn` low 5 cycles, then release. Expect `o_valid=0`, `o_req_count=NONE`, `o_ready=0` during reset; `o_ready=1` the first cycle after release.
- **Store then load:** SW 0xDEADBEEF to 0x40, then LW 0x40. The store gives a request `WORD`/`wr_en=1`, then `o_valid` with `o_rd_wr_en=0`, `o_exc=0`. The load gives `o_rd_data=0xDEADBEEF` one cycle after its accept.
- **Load extension:** SB 0x80 to 0x13 and SH 0x8001 to 0x20. Then:
  - LB 0x13 returns 0xFFFFFF80; LBU 0x13 returns 0x00000080.
  - LH 0x20 returns 0xFFFF8001; LHU 0x20 returns 0x00008001.
- **Alignment and illegal checks:** LH 0x21, LW 0x22, SW 0x23 each give `o_req_count=NONE`, `o_exc=1`, `o_rd_wr_en=0`. `funct3=011` load gives `o_exc=2`.
- **Fault:** drive `i_res_code` to a non-READ code for a LW. Expect `o_exc=3`, `o_rd_wr_en=0`.
- **Backpressure:** stream 8 back-to-back loads with `i_ready` low for 4 cycles mid-stream. Expect `o_ready` to drop after 2 results are held. All 8 results arrive in order with correct data and none are duplicated or lost.
